// File: rtl/poly_sample_mixer_pkg.sv
// Shared definitions for the poly sample mixer: FSM state encoding, default sample width
// and a constant-evaluable ceil(log2) helper used to size the accumulator and index counter.
package poly_sample_mixer_pkg;

  localparam int unsigned DefaultSampleW = 16;

  typedef enum logic [2:0] {
    StIdle,
    StRequest,
    StCollect,
    StSum,
    StDone
  } mix_state_e;

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int unsigned mixer_clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/poly_sample_mixer_saturator.sv
// Combinational clamp of a wide signed accumulator into a signed SAMPLE_W result,
// flagging when either limit was applied. Reusable wherever a wide sum must be narrowed.
module poly_sample_mixer_saturator #(
  parameter int unsigned ACC_W    = 18,
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic signed [ACC_W-1:0]    i_acc,
  output logic        [SAMPLE_W-1:0] o_sample,
  output logic                       o_clip
);

  localparam logic signed [ACC_W-1:0] MaxVal =
    {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MinVal =
    {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  // Clamp to the representable signed range of the output width
  always_comb begin
    o_sample = i_acc[SAMPLE_W-1:0];
    o_clip   = 1'b0;
    if (i_acc > MaxVal) begin
      o_sample = MaxVal[SAMPLE_W-1:0];
      o_clip   = 1'b1;
    end else if (i_acc < MinVal) begin
      o_sample = MinVal[SAMPLE_W-1:0];
      o_clip   = 1'b1;
    end
  end

endmodule

// File: rtl/poly_sample_mixer.sv
// N-voice saturating sample mixer feeding the codec. One request per codec frame, per-voice
// ready collection with a timeout, serial accumulation, then saturation into a pending register
// that is presented on the following frame edge.
// Optional feature macro: MIXER_GAIN_EN (adds gain_shift, arithmetic right shift before clamp).
module poly_sample_mixer
  import poly_sample_mixer_pkg::*;
#(
  parameter int unsigned VOICES   = 3,
  parameter int unsigned SAMPLE_W = DefaultSampleW,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         new_frame,
  input  logic [VOICES-1:0]            voice_en,
  input  logic [VOICES*SAMPLE_W-1:0]   voice_sample,
  input  logic [VOICES-1:0]            voice_ready,
`ifdef MIXER_GAIN_EN
  input  logic [3:0]                   gain_shift,
`endif
  output logic                         generate_next_sample,
  output logic                         new_sample_generated,
  output logic                         clip,
  output logic                         timeout,
  output logic [SAMPLE_W-1:0]          sample_out
);

  localparam int unsigned LogV = mixer_clog2(VOICES);
  localparam int unsigned IdxW = (LogV > 0) ? LogV : 1;
  localparam int unsigned AccW = SAMPLE_W + LogV;

  mix_state_e                r_state, w_state_next;
  logic                      r_frame_q;
  logic                      w_frame_pulse;
  logic [VOICES-1:0]         r_got;
  logic [SAMPLE_W-1:0]       r_buf [VOICES];
  logic [7:0]                r_cnt;
  logic [IdxW-1:0]           r_idx;
  logic signed [AccW-1:0]    r_acc;
  logic signed [AccW-1:0]    w_shifted;
  logic signed [SAMPLE_W-1:0] w_sel;
  logic signed [AccW-1:0]    w_sel_ext;
  logic [SAMPLE_W-1:0]       r_pending;
  logic [SAMPLE_W-1:0]       r_sample_out;
  logic                      r_timeout;
  logic [SAMPLE_W-1:0]       w_sat_sample;
  logic                      w_sat_clip;
  logic                      w_all_got;
  logic                      w_timeout_hit;
  logic                      w_last_idx;

  assign w_frame_pulse = new_frame & ~r_frame_q;
  assign w_all_got     = &r_got;
  assign w_timeout_hit = (r_cnt == 8'(TIMEOUT - 1));
  assign w_last_idx    = (r_idx == IdxW'(VOICES - 1));
  assign w_sel         = r_buf[r_idx];
  assign w_sel_ext     = AccW'(w_sel);

`ifdef MIXER_GAIN_EN
  logic [3:0] r_gain;

  // Gain is captured with the request so a mid-frame change waits for the next frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gain <= 4'd0;
    end else if (r_state == StRequest) begin
      r_gain <= gain_shift;
    end
  end

  assign w_shifted = r_acc >>> r_gain;
`else
  assign w_shifted = r_acc;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; frame edges outside IDLE never start a new request
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (w_frame_pulse) w_state_next = StRequest;
      StRequest: w_state_next = StCollect;
      StCollect: if (w_all_got || w_timeout_hit) w_state_next = StSum;
      StSum:     if (w_last_idx) w_state_next = StDone;
      StDone:    w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // Moore pulse outputs
  always_comb begin
    generate_next_sample = (r_state == StRequest);
    new_sample_generated = (r_state == StDone);
    clip                 = (r_state == StDone) & w_sat_clip;
  end

  // Disabled voices start as already collected so they are never waited for
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_got <= '0;
    end else if (r_state == StRequest) begin
      r_got <= ~voice_en;
    end else if (r_state == StCollect) begin
      r_got <= r_got | voice_ready;
    end
  end

  for (genvar gi = 0; gi < VOICES; gi++) begin : g_voice
    // Per-voice buffer: cleared on request so missing voices contribute 0; first ready wins
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_buf[gi] <= '0;
      end else if (r_state == StRequest) begin
        r_buf[gi] <= '0;
      end else if ((r_state == StCollect) && voice_ready[gi] && !r_got[gi]) begin
        r_buf[gi] <= voice_sample[gi*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  // Datapath: edge register, collect timer, serial accumulate, pending and codec output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_q    <= 1'b0;
      r_cnt        <= 8'd0;
      r_idx        <= '0;
      r_acc        <= '0;
      r_timeout    <= 1'b0;
      r_pending    <= '0;
      r_sample_out <= '0;
    end else begin
      r_frame_q <= new_frame;
      if (w_frame_pulse) begin
        r_sample_out <= r_pending;
      end
      case (r_state)
        StRequest: begin
          r_cnt <= 8'd0;
          r_idx <= '0;
          r_acc <= '0;
        end
        StCollect: begin
          r_cnt <= r_cnt + 8'd1;
          if (!w_all_got && w_timeout_hit) begin
            r_timeout <= 1'b1;
          end
        end
        StSum: begin
          r_acc <= r_acc + w_sel_ext;
          r_idx <= r_idx + IdxW'(1);
        end
        StDone: r_pending <= w_sat_sample;
        default: ;
      endcase
    end
  end

  poly_sample_mixer_saturator #(
    .ACC_W    (AccW),
    .SAMPLE_W (SAMPLE_W)
  ) u_sat (
    .i_acc    (w_shifted),
    .o_sample (w_sat_sample),
    .o_clip   (w_sat_clip)
  );

  assign timeout    = r_timeout;
  assign sample_out = r_sample_out;

endmodule
